// File: rtl/a2d_scan_intf_pkg.sv
// Shared types and constants for the ADC128S-family scan interface.
// The frame FSM states, the mode FSM states and the command-word builder
// live here so the top and the SPI frame engine agree on them.
package a2d_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CH_W       = 3;
    localparam int ADC_W      = 12;

    // One SPI frame: select setup, 16 SCLK periods, select hold, deselect gap.
    typedef enum logic [2:0] {
        IDLE,
        FRONT,
        SHIFT,
        BACK,
        GAP
    } frame_state_t;

    // Request-level mode: what the sequence of frames is being used for.
    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_SINGLE,
        MODE_SCAN,
        MODE_FINISH
    } mode_state_t;

    // Control word: two don't-care zeros, channel address, then 11 zeros.
    function automatic logic [FRAME_BITS-1:0] build_cmd(input logic [CH_W-1:0] ch);
        return {2'b00, ch, 11'b0};
    endfunction

endpackage

// File: rtl/a2d_scan_intf_if.sv
// Bundle of request/result/bank-read signals plus the ADC SPI pins.
// master: the requesting logic (and the ADC on MISO); slave: a2d_scan_intf.
interface a2d_scan_intf_if #(
    parameter int RES_W = 12
);
    logic                      strt_cnv;
    logic [a2d_pkg::CH_W-1:0]  chnnl;
    logic                      scan_en;
    logic                      busy;
    logic                      cnv_cmplt;
    logic [RES_W-1:0]          res;
    logic [a2d_pkg::CH_W-1:0]  res_ch;
    logic [a2d_pkg::CH_W-1:0]  rd_ch;
    logic [RES_W-1:0]          rd_data;
    logic                      rd_vld;
    logic                      SS_n;
    logic                      SCLK;
    logic                      MOSI;
    logic                      MISO;

    modport master (
        output strt_cnv, chnnl, scan_en, rd_ch, MISO,
        input  busy, cnv_cmplt, res, res_ch, rd_data, rd_vld, SS_n, SCLK, MOSI
    );

    modport slave (
        input  strt_cnv, chnnl, scan_en, rd_ch, MISO,
        output busy, cnv_cmplt, res, res_ch, rd_data, rd_vld, SS_n, SCLK, MOSI
    );

endinterface

// File: rtl/a2d_scan_intf_spi_frame16.sv
// spi_frame16: generates one 16-bit SPI frame per request.
// SCLK idles high, falls at the start of each period (MOSI updates there)
// and rises mid-period (MISO sampled there). go is a level: it is looked at
// in IDLE and again at the end of GAP so back-to-back frames need no idle cycle.
module spi_frame16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [FRAME_BITS-1:0] cmd,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx,
    output logic                  SS_n,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int CNT_W = $clog2(SCLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(SCLK_DIV - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(FRAME_BITS - 1);

    frame_state_t          state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic [3:0]            bit_reg;
    logic [FRAME_BITS-1:0] tx_reg, rx_reg;
    logic                  ss_n_reg, sclk_reg, mosi_reg;
    logic                  half_last, per_last, cnt_clr;
    logic                  load, sclk_fall, sclk_rise;

    assign half_last = (cnt_reg == HALF_LAST);
    assign per_last  = (cnt_reg == PER_LAST);
    assign cnt_clr   = (state_next != state_reg) || (state_reg == IDLE) || per_last;

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Phase sequencing and the SCLK edge strobes.
    always_comb begin
        state_next = state_reg;
        done       = 1'b0;
        load       = 1'b0;
        sclk_fall  = 1'b0;
        sclk_rise  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (go) begin
                    state_next = FRONT;
                    load       = 1'b1;
                end
            end
            FRONT: begin
                if (half_last) begin
                    state_next = SHIFT;
                    sclk_fall  = 1'b1;
                end
            end
            SHIFT: begin
                if (half_last) sclk_rise = 1'b1;
                if (per_last) begin
                    if (bit_reg == BIT_LAST) state_next = BACK;
                    else                     sclk_fall  = 1'b1;
                end
            end
            BACK: begin
                if (half_last) begin
                    state_next = GAP;
                    done       = 1'b1;
                end
            end
            GAP: begin
                if (half_last) begin
                    if (go) begin
                        state_next = FRONT;
                        load       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, shift registers and the registered SPI pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            bit_reg  <= '0;
            tx_reg   <= '0;
            rx_reg   <= '0;
            ss_n_reg <= 1'b1;
            sclk_reg <= 1'b1;
            mosi_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_clr ? '0 : cnt_reg + 1'b1;
            if (load) begin
                tx_reg   <= cmd;
                ss_n_reg <= 1'b0;
            end
            if (done) ss_n_reg <= 1'b1;
            if (sclk_fall) begin
                sclk_reg <= 1'b0;
                mosi_reg <= tx_reg[FRAME_BITS-1];
                tx_reg   <= {tx_reg[FRAME_BITS-2:0], 1'b0};
                bit_reg  <= (state_reg == FRONT) ? 4'd0 : bit_reg + 4'd1;
            end
            if (sclk_rise) begin
                sclk_reg <= 1'b1;
                rx_reg   <= {rx_reg[FRAME_BITS-2:0], MISO};
            end
        end
    end

    assign rx   = rx_reg;
    assign SS_n = ss_n_reg;
    assign SCLK = sclk_reg;
    assign MOSI = mosi_reg;

endmodule

// File: rtl/a2d_scan_intf.sv
// a2d_scan_intf: ADC128S-family SPI master with single-shot and round-robin
// scan modes. The converter answers each frame with the channel addressed in
// the frame before, so prev_ch/prev_valid follow which channel the incoming
// data belongs to. Results land in res/res_ch and a per-channel bank.
// Optional build macro A2D_SCAN_AVG_EN: bank writes to a valid entry store the
// rounded mean of the old entry and the new sample.
module a2d_scan_intf
    import a2d_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int SCLK_DIV = 32,
    parameter int RES_W    = 12
) (
    input logic              clk,
    input logic              rst,
    a2d_scan_intf_if.slave   bus
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    mode_state_t           mode_reg, mode_next;
    logic                  start_single, start_scan, advance, capture, go, done;
    logic [CH_W-1:0]       cur_ch_reg, prev_ch_reg, cmd_ch, next_ch;
    logic                  prev_valid_reg;
    logic [FRAME_BITS-1:0] cmd, rx;
    logic [RES_W-1:0]      sample, wr_data;
    logic [FRAME_BITS-1:0] rx_unused;
    logic [RES_W-1:0]      res_reg;
    logic [CH_W-1:0]       res_ch_reg;
    logic                  cnv_cmplt_reg;
    logic [RES_W-1:0]      bank_mem  [NUM_CH];
    logic                  valid_mem [NUM_CH];

    // Mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_reg <= MODE_IDLE;
        else     mode_reg <= mode_next;
    end

    // Request arbitration, frame continuation and capture decisions.
    always_comb begin
        mode_next    = mode_reg;
        start_single = 1'b0;
        start_scan   = 1'b0;
        advance      = 1'b0;
        capture      = 1'b0;
        go           = 1'b0;
        case (mode_reg)
            MODE_IDLE: begin
                if (bus.strt_cnv) begin
                    start_single = 1'b1;
                    go           = 1'b1;
                    mode_next    = MODE_SINGLE;
                end else if (bus.scan_en) begin
                    start_scan = 1'b1;
                    go         = 1'b1;
                    mode_next  = MODE_SCAN;
                end
            end
            MODE_SINGLE: begin
                go = 1'b1;
                if (done) begin
                    advance = 1'b1;
                    capture = prev_valid_reg;
                    if (prev_valid_reg) mode_next = MODE_FINISH;
                end
            end
            MODE_SCAN: begin
                go = 1'b1;
                if (done) begin
                    advance = 1'b1;
                    capture = prev_valid_reg;
                    if (!bus.scan_en) mode_next = MODE_FINISH;
                end
            end
            MODE_FINISH: mode_next = MODE_IDLE;
            default:     mode_next = MODE_IDLE;
        endcase
    end

    // The first frame of a request addresses the requested channel directly
    // so SS_n can fall on the clock after acceptance.
    assign cmd_ch  = (mode_reg == MODE_IDLE) ? (bus.strt_cnv ? bus.chnnl : '0) : cur_ch_reg;
    assign cmd     = build_cmd(cmd_ch);
    assign next_ch = (cur_ch_reg == LAST_CH) ? '0 : cur_ch_reg + 3'd1;

    assign sample    = rx[RES_W-1:0];
    assign rx_unused = rx >> RES_W;

    spi_frame16 #(
        .SCLK_DIV (SCLK_DIV)
    ) u_frame (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .cmd  (cmd),
        .done (done),
        .rx   (rx),
        .SS_n (bus.SS_n),
        .SCLK (bus.SCLK),
        .MOSI (bus.MOSI),
        .MISO (bus.MISO)
    );

    // Channel pipeline tracking and the result/complete registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ch_reg     <= '0;
            prev_ch_reg    <= '0;
            prev_valid_reg <= 1'b0;
            res_reg        <= '0;
            res_ch_reg     <= '0;
            cnv_cmplt_reg  <= 1'b0;
        end else begin
            cnv_cmplt_reg <= capture;
            if (start_single) begin
                cur_ch_reg     <= bus.chnnl;
                prev_valid_reg <= 1'b0;
            end else if (start_scan) begin
                cur_ch_reg     <= '0;
                prev_valid_reg <= 1'b0;
            end else if (advance) begin
                prev_ch_reg    <= cur_ch_reg;
                prev_valid_reg <= 1'b1;
                if (mode_reg == MODE_SCAN) cur_ch_reg <= next_ch;
            end
            if (capture) begin
                res_reg    <= sample;
                res_ch_reg <= prev_ch_reg;
            end
        end
    end

`ifdef A2D_SCAN_AVG_EN
    logic [RES_W-1:0] old_data;
    logic             old_valid;
    logic [RES_W:0]   avg_sum;

    // Current bank contents of the channel being written.
    always_comb begin
        old_data  = '0;
        old_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (prev_ch_reg == CH_W'(i)) begin
                old_data  = bank_mem[i];
                old_valid = valid_mem[i];
            end
        end
    end

    assign avg_sum = {1'b0, old_data} + {1'b0, sample} + 1'b1;
    assign wr_data = old_valid ? RES_W'(avg_sum >> 1) : sample;
`else
    assign wr_data = sample;
`endif

    // One bank entry per scanned channel; reset invalidates every entry.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bank
            logic wr_hit;
            assign wr_hit = capture && (prev_ch_reg == CH_W'(gi));

            // Entry write on a capture addressed to this channel.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bank_mem[gi]  <= '0;
                    valid_mem[gi] <= 1'b0;
                end else if (wr_hit) begin
                    bank_mem[gi]  <= wr_data;
                    valid_mem[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Combinational bank read; addresses beyond NUM_CH read as empty.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_vld  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_ch == CH_W'(i)) begin
                bus.rd_data = bank_mem[i];
                bus.rd_vld  = valid_mem[i];
            end
        end
    end

    assign bus.busy      = (mode_reg != MODE_IDLE);
    assign bus.cnv_cmplt = cnv_cmplt_reg;
    assign bus.res       = res_reg;
    assign bus.res_ch    = res_ch_reg;

endmodule

// File: tb/tb_a2d_scan_intf.sv
// Directed bench for a2d_scan_intf with a behavioural ADC128S model that
// returns the value of the channel addressed in the previous frame.
module tb_a2d_scan_intf;

    localparam int NUM_CH   = 4;
    localparam int SCLK_DIV = 4;
    localparam int RES_W    = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    a2d_scan_intf_if #(.RES_W(RES_W)) bus ();

    a2d_scan_intf #(
        .NUM_CH   (NUM_CH),
        .SCLK_DIV (SCLK_DIV),
        .RES_W    (RES_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ADC model state
    logic [11:0] adc_val [8];
    logic [2:0]  adc_prev = 3'd0;
    logic [15:0] adc_out  = 16'd0;
    logic [15:0] adc_in   = 16'd0;
    int          frames   = 0;

    always @(negedge bus.SS_n) begin
        adc_out = {4'h0, adc_val[adc_prev]};
        adc_in  = 16'd0;
    end
    always @(negedge bus.SCLK) begin
        if (bus.SS_n === 1'b0) begin
            bus.MISO = adc_out[15];
            adc_out  = {adc_out[14:0], 1'b0};
        end
    end
    always @(posedge bus.SCLK) begin
        if (bus.SS_n === 1'b0) adc_in = {adc_in[14:0], bus.MOSI};
    end
    always @(posedge bus.SS_n) begin
        adc_prev = adc_in[13:11];
        frames   = frames + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cmplt(input string tag, output int cyc);
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (bus.cnv_cmplt !== 1'b1 && cyc < 3000);
        check({tag, "_cmplt_seen"}, (cyc < 3000), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 3000) begin
            tick(1);
            n++;
        end
        check("idle_seen", (n < 3000), 1);
    endtask

    task automatic single(input logic [2:0] ch, output int cyc);
        wait_idle();
        bus.chnnl    = ch;
        bus.strt_cnv = 1'b1;
        tick(1);
        bus.strt_cnv = 1'b0;
        wait_cmplt("single", cyc);
        $display("single ch=%0d res=%0h res_ch=%0d cycles=%0d", ch, bus.res, bus.res_ch, cyc);
    endtask

    int cyc;
    int fr_snap;

    initial begin
        adc_val[0] = 12'h123; adc_val[1] = 12'h456; adc_val[2] = 12'h789; adc_val[3] = 12'hC35;
        adc_val[4] = 12'hABC; adc_val[5] = 12'h0F0; adc_val[6] = 12'hFFF; adc_val[7] = 12'h001;
        rst          = 1'b1;
        bus.strt_cnv = 1'b0;
        bus.chnnl    = 3'd0;
        bus.scan_en  = 1'b0;
        bus.rd_ch    = 3'd0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset values
        check("rst_SS_n", bus.SS_n, 1);
        check("rst_SCLK", bus.SCLK, 1);
        check("rst_MOSI", bus.MOSI, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cmplt", bus.cnv_cmplt, 0);
        check("rst_res", bus.res, 0);
        check("rst_res_ch", bus.res_ch, 0);
        for (int i = 0; i < 8; i++) begin
            bus.rd_ch = 3'(i);
            #1;
            check("rst_rd_vld", bus.rd_vld, 0);
        end

        // First single conversion on ch3: two frames, latency, busy fall
        frames = 0;
        single(3'd3, cyc);
        check("latency", (cyc >= 2 * 17 * SCLK_DIV + SCLK_DIV / 2 - 1) && (cyc <= 2 * 17 * SCLK_DIV + SCLK_DIV / 2 + 1), 1);
        check("ch3_res", bus.res, 12'hC35);
        check("ch3_res_ch", bus.res_ch, 3);
        check("ch3_busy_at_cmplt", bus.busy, 1);
        check("ch3_frames", frames, 2);
        tick(1);
        check("ch3_cmplt_pulse", bus.cnv_cmplt, 0);
        check("ch3_busy_after", bus.busy, 0);
        tick(100);
        check("ch3_no_more_frames", frames, 2);
        check("ch3_SS_n_idle", bus.SS_n, 1);

        // Single conversions on all eight channels
        for (int ch = 0; ch < 8; ch++) begin
            single(3'(ch), cyc);
            check("sweep_res", bus.res, adc_val[ch]);
            check("sweep_res_ch", bus.res_ch, ch);
        end
        for (int i = 0; i < 8; i++) begin
            bus.rd_ch = 3'(i);
            #1;
            $display("bank rd_ch=%0d rd_data=%0h rd_vld=%0d", i, bus.rd_data, bus.rd_vld);
            check("sweep_rd_data", bus.rd_data, (i < NUM_CH) ? adc_val[i] : 12'h000);
            check("sweep_rd_vld", bus.rd_vld, (i < NUM_CH) ? 1 : 0);
        end

        // Scan: three rounds, with an ignored strt_cnv in the middle
        wait_idle();
        bus.scan_en = 1'b1;
        for (int k = 0; k < 3 * NUM_CH; k++) begin
            wait_cmplt("scan", cyc);
            $display("scan cmplt k=%0d res_ch=%0d res=%0h", k, bus.res_ch, bus.res);
            check("scan_res_ch", bus.res_ch, k % NUM_CH);
            check("scan_res", bus.res, adc_val[k % NUM_CH]);
            if (k == 5) begin
                bus.chnnl    = 3'd2;
                bus.strt_cnv = 1'b1;
                tick(1);
                bus.strt_cnv = 1'b0;
            end
        end
        // Drop scan_en mid-frame: that frame still completes and is stored
        tick(10);
        check("scan_in_frame", bus.SS_n, 0);
        bus.scan_en = 1'b0;
        wait_cmplt("scan_stop", cyc);
        $display("scan stop res_ch=%0d res=%0h", bus.res_ch, bus.res);
        check("stop_res_ch", bus.res_ch, 0);
        check("stop_res", bus.res, adc_val[0]);
        tick(1);
        check("stop_busy", bus.busy, 0);
        fr_snap = frames;
        tick(200);
        check("stop_no_frames", frames, fr_snap);
        check("stop_SS_n", bus.SS_n, 1);
        bus.rd_ch = 3'd5;
        #1;
        check("rd5_data", bus.rd_data, 0);
        check("rd5_vld", bus.rd_vld, 0);
        bus.rd_ch = 3'd1;
        #1;
        check("rd1_data", bus.rd_data, adc_val[1]);
        check("rd1_vld", bus.rd_vld, 1);

        // Reset during SHIFT of frame A
        bus.chnnl    = 3'd2;
        bus.strt_cnv = 1'b1;
        tick(1);
        bus.strt_cnv = 1'b0;
        tick(20);
        check("pre_rst_SS_n", bus.SS_n, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_SS_n", bus.SS_n, 1);
        check("mid_rst_SCLK", bus.SCLK, 1);
        check("mid_rst_busy", bus.busy, 0);
        for (int i = 0; i < NUM_CH; i++) begin
            bus.rd_ch = 3'(i);
            #1;
            check("mid_rst_rd_vld", bus.rd_vld, 0);
        end
        tick(2);
        rst = 1'b0;
        tick(1);
        single(3'd1, cyc);
        check("post_rst_res", bus.res, adc_val[1]);
        check("post_rst_res_ch", bus.res_ch, 1);
        bus.rd_ch = 3'd1;
        #1;
        check("post_rst_rd_vld", bus.rd_vld, 1);

        // Two conversions of ch2 into a freshly invalidated entry
        adc_val[2] = 12'h100;
        single(3'd2, cyc);
        bus.rd_ch = 3'd2;
        #1;
        check("avg_first_bank", bus.rd_data, 12'h100);
        check("avg_first_vld", bus.rd_vld, 1);
        adc_val[2] = 12'h201;
        single(3'd2, cyc);
        check("avg_second_res", bus.res, 12'h201);
        #1;
`ifdef A2D_SCAN_AVG_EN
        check("avg_second_bank", bus.rd_data, 12'h181);
`else
        check("avg_second_bank", bus.rd_data, 12'h201);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
